// File: rtl/instruction_decode.sv
// MIPS decode stage: IF/ID register, 32x32 register file, load-use hazard
// detection, J-type resolution and a registered ID/EX bundle.
module instruction_decode #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 5,
  parameter int RF_AW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic [PC_W-1:0]   pc_4,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [RF_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  input  logic [RF_AW-1:0]  ex_rt,
  output logic              stall,
  output logic              mux_ctrl,
  output logic [PC_W-1:0]   jp_address,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [RF_AW-1:0]  rs,
  output logic [RF_AW-1:0]  rt,
  output logic [RF_AW-1:0]  rd,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm_ext,
  output logic [PC_W-1:0]   pc_4_out,
  output logic              id_valid
);

  localparam int NREG = 1 << RF_AW;

  typedef struct packed {
    logic [5:0]        op;
    logic [5:0]        fn;
    logic [RF_AW-1:0]  rs;
    logic [RF_AW-1:0]  rt;
    logic [RF_AW-1:0]  rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc;
    logic              valid;
  } id_ex_t;

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  id_ex_t            ex_q, ex_d;

  logic [5:0]        op;
  logic [5:0]        fn;
  logic [RF_AW-1:0]  rs_a;
  logic [RF_AW-1:0]  rt_a;
  logic [RF_AW-1:0]  rd_a;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm;
  logic              uses_rt;
  logic              zext;
  logic              is_j;

  assign op   = instr_q[31:26];
  assign rs_a = instr_q[25:21];
  assign rt_a = instr_q[20:16];
  assign rd_a = instr_q[15:11];
  assign fn   = instr_q[5:0];

  always_comb begin
    uses_rt = 1'b0;
    zext    = 1'b0;
    is_j    = 1'b0;
    unique case (1'b1)
      op == 6'h00,
      op == 6'h04,
      op == 6'h05,
      op == 6'h2B: uses_rt = 1'b1;
      op == 6'h0C,
      op == 6'h0D,
      op == 6'h0E: zext = 1'b1;
      op == 6'h02: is_j = 1'b1;
      default: ;
    endcase
  end

  // Write-through so a same-cycle write-back is seen by decode
  always_comb begin
    rs_val = rf_q[rs_a];
    rt_val = rf_q[rt_a];
    if (wb_we && wb_addr == rs_a) rs_val = wb_data;
    if (wb_we && wb_addr == rt_a) rt_val = wb_data;
    if (rs_a == '0) rs_val = '0;
    if (rt_a == '0) rt_val = '0;
  end

  always_comb begin
    imm = {{16{instr_q[15]}}, instr_q[15:0]};
    if (zext) imm = {16'b0, instr_q[15:0]};
  end

  assign stall = valid_q & ex_mem_read & (ex_rt != '0)
               & ((ex_rt == rs_a) | (uses_rt & (ex_rt == rt_a)));

  assign mux_ctrl   = valid_q & is_j & ~stall & ~flush;
  assign jp_address = instr_q[PC_W-1:0];

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = '0;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = instruction;
      pc_d    = pc_4;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_we && wb_addr != '0) rf_d[wb_addr] = wb_data;
  end

  always_comb begin
    ex_d = '0;
    if (valid_q && !stall && !flush) begin
      ex_d.op      = op;
      ex_d.fn      = fn;
      ex_d.rs      = rs_a;
      ex_d.rt      = rt_a;
      ex_d.rd      = rd_a;
      ex_d.rs_data = rs_val;
      ex_d.rt_data = rt_val;
      ex_d.imm     = imm;
      ex_d.pc      = pc_q;
      ex_d.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      ex_q    <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ex_q    <= ex_d;
      rf_q    <= rf_d;
    end
  end

  assign opcode   = ex_q.op;
  assign funct    = ex_q.fn;
  assign rs       = ex_q.rs;
  assign rt       = ex_q.rt;
  assign rd       = ex_q.rd;
  assign rs_data  = ex_q.rs_data;
  assign rt_data  = ex_q.rt_data;
  assign imm_ext  = ex_q.imm;
  assign pc_4_out = ex_q.pc;
  assign id_valid = ex_q.valid;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed decode vectors,
// hazard, jump, immediate and reset cases.
module tb_instruction_decode;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  pc_4;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        stall;
  logic        mux_ctrl;
  logic [4:0]  jp_address;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  pc_4_out;
  logic        id_valid;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  pc;
  } rec_t;

  rec_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  instruction_decode dut (
    .clk(clk), .reset(reset), .instruction(instruction), .pc_4(pc_4),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .stall(stall),
    .mux_ctrl(mux_ctrl), .jp_address(jp_address), .opcode(opcode),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .rs_data(rs_data),
    .rt_data(rt_data), .imm_ext(imm_ext), .pc_4_out(pc_4_out),
    .id_valid(id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(
    input logic [5:0] op, input logic [5:0] fn,
    input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
    input logic [31:0] ad, input logic [31:0] bd,
    input logic [31:0] im, input logic [4:0] pc);
    rec_t r;
    r = {op, fn, a, b, c, ad, bd, im, pc};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Monitor: every issued ID/EX entry is matched against the scoreboard
  always begin
    rec_t act;
    rec_t e;
    @(posedge clk);
    #1;
    if (id_valid === 1'b1) begin
      act = {opcode, funct, rs, rt, rd, rs_data, rt_data, imm_ext, pc_4_out};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue: got %0h, expected no entry", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL id_ex: got %0h, expected %0h", act, e);
        end
      end
    end
  end

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    flush = 1'b1; wb_we = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    wb_we = 1'b0;
  endtask

  // Load ins into IF/ID, then hold it for one decode cycle with the
  // given side inputs; checks combinational hazard/jump outputs.
  task automatic dec(
    input string nm, input logic [31:0] ins, input logic [4:0] pc,
    input logic fl, input logic mr, input logic [4:0] ert,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic es, input logic em, input bit push, input rec_t e);
    logic [31:0] iv;
    iv = ins;
    @(negedge clk);
    instruction = ins; pc_4 = pc; flush = 1'b0;
    wb_we = 1'b0; ex_mem_read = 1'b0;
    @(negedge clk);
    instruction = 32'h0; pc_4 = 5'h0; flush = fl;
    ex_mem_read = mr; ex_rt = ert;
    wb_we = we; wb_addr = wa; wb_data = wd;
    if (push) exp_q.push_back(e);
    #1;
    chk({nm, "_stall"}, {127'b0, stall}, {127'b0, es});
    chk({nm, "_mux"}, {127'b0, mux_ctrl}, {127'b0, em});
    chk({nm, "_jp"}, {123'b0, jp_address}, {123'b0, iv[4:0]});
    @(negedge clk);
    flush = 1'b1; ex_mem_read = 1'b0; wb_we = 1'b0;
    if (!push) chk({nm, "_bubble"}, {127'b0, id_valid}, 128'b0);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {opcode, funct, rs, rt, rd, rs_data, rt_data, imm_ext,
             pc_4_out, id_valid, stall, mux_ctrl},
        128'b0);
  endtask

  initial begin
    reset = 1'b0; instruction = 32'h0; pc_4 = 5'h0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = 5'h0; wb_data = 32'h0;
    ex_mem_read = 1'b0; ex_rt = 5'h0;

    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("reset_outs");
    flush = 1'b1;

    wb(5'd5, 32'hDEADBEEF);
    dec("add_r5", 32'h00A01820, 5'h04, 1'b0, 1'b0, 5'd0,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1,
        mk(6'h00, 6'h20, 5'd5, 5'd0, 5'd3, 32'hDEADBEEF, 32'h0,
           32'h00001820, 5'h04));
    dec("r0_write", 32'h00002020, 5'h08, 1'b0, 1'b0, 5'd0,
        1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 1'b1,
        mk(6'h00, 6'h20, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0,
           32'h00002020, 5'h08));
    dec("bypass_r7", 32'h00E04020, 5'h0C, 1'b0, 1'b0, 5'd0,
        1'b1, 5'd7, 32'h55, 1'b0, 1'b0, 1'b1,
        mk(6'h00, 6'h20, 5'd7, 5'd0, 5'd8, 32'h55, 32'h0,
           32'h00004020, 5'h0C));
    dec("read_r7", 32'h00074820, 5'h10, 1'b0, 1'b0, 5'd0,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1,
        mk(6'h00, 6'h20, 5'd0, 5'd7, 5'd9, 32'h0, 32'h55,
           32'h00004820, 5'h10));

    // Load-use stall: one bubble, then the held add issues
    @(negedge clk);
    instruction = 32'h00A01820; pc_4 = 5'h06; flush = 1'b0;
    @(negedge clk);
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    instruction = 32'hFFFFFFFF; pc_4 = 5'h1F;
    exp_q.push_back(mk(6'h00, 6'h20, 5'd5, 5'd0, 5'd3, 32'hDEADBEEF,
                       32'h0, 32'h00001820, 5'h06));
    #1;
    chk("lu_stall_hi", {127'b0, stall}, 128'd1);
    @(negedge clk);
    chk("lu_bubble", {127'b0, id_valid}, 128'b0);
    ex_mem_read = 1'b0; instruction = 32'h0; pc_4 = 5'h0;
    #1;
    chk("lu_stall_lo", {127'b0, stall}, 128'b0);
    @(negedge clk);
    flush = 1'b1;

    dec("sw_rt", 32'hACC90000, 5'h01, 1'b1, 1'b1, 5'd9,
        1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, '0);
    dec("addi_rt", 32'h20C90001, 5'h01, 1'b1, 1'b1, 5'd9,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
    dec("addi_rs", 32'h20C90001, 5'h01, 1'b1, 1'b1, 5'd6,
        1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, '0);
    dec("beq_rt", 32'h10C90000, 5'h01, 1'b1, 1'b1, 5'd9,
        1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, '0);
    dec("ex_rt0", 32'h00001820, 5'h01, 1'b1, 1'b1, 5'd0,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
    dec("no_load", 32'hACC90000, 5'h01, 1'b1, 1'b0, 5'd9,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0);

    dec("jump", 32'h0800000C, 5'h1C, 1'b0, 1'b0, 5'd0,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1,
        mk(6'h02, 6'h0C, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,
           32'h0000000C, 5'h1C));
    dec("jump_flush", 32'h0800000C, 5'h1E, 1'b1, 1'b0, 5'd0,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0);

    dec("addi_sext", 32'h2001FFFE, 5'h14, 1'b0, 1'b0, 5'd0,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1,
        mk(6'h08, 6'h3E, 5'd0, 5'd1, 5'd31, 32'h0, 32'h0,
           32'hFFFFFFFE, 5'h14));
    dec("ori_zext", 32'h3401FFFE, 5'h18, 1'b0, 1'b0, 5'd0,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1,
        mk(6'h0D, 6'h3E, 5'd0, 5'd1, 5'd31, 32'h0, 32'h0,
           32'h0000FFFE, 5'h18));
    dec("andi_zext", 32'h30008000, 5'h1A, 1'b0, 1'b0, 5'd0,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1,
        mk(6'h0C, 6'h00, 5'd0, 5'd0, 5'd16, 32'h0, 32'h0,
           32'h00008000, 5'h1A));

    // Reset mid-run clears the register file; the write is dropped
    @(negedge clk);
    reset = 1'b0; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hABCD;
    @(negedge clk);
    reset = 1'b1; wb_we = 1'b0; flush = 1'b1;
    #1;
    chk_zero("mid_reset_outs");
    dec("post_reset", 32'h00A91820, 5'h03, 1'b0, 1'b0, 5'd0,
        1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1,
        mk(6'h00, 6'h20, 5'd5, 5'd9, 5'd3, 32'h0, 32'h0,
           32'h00001820, 5'h03));

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'b0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
